axis_pow3_checker: RTL and testbench
====================================

AXIS_POW3_CHECKER -- requirements
Module: axis_pow3_checker

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 32, giving the stream data width in bits (a multiple of 8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the buffer depth in entries (a power of 2, at least 2).
REQ-003 The block SHALL have port aclk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port areset, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port s00_axis_tdata, input, width DATA_SIZE: upstream data from the power-of-3 generator.
REQ-006 The block SHALL have port s00_axis_tstrb, input, width DATA_SIZE/8: upstream byte strobes.
REQ-007 The block SHALL have port s00_axis_tvalid, input, width 1: upstream beat valid.
REQ-008 The block SHALL have port s00_axis_tready, output, width 1: the block can accept a beat.
REQ-009 The block SHALL have port s00_axis_tlast, input, width 1: upstream last flag.
REQ-010 The block SHALL have port m00_axis_tdata, output, width DATA_SIZE: downstream data.
REQ-011 The block SHALL have port m00_axis_tstrb, output, width DATA_SIZE/8: downstream strobes.
REQ-012 The block SHALL have port m00_axis_tvalid, output, width 1: downstream beat valid.
REQ-013 The block SHALL have port m00_axis_tready, input, width 1: downstream can accept a beat.
REQ-014 The block SHALL have port m00_axis_tlast, output, width 1: downstream last flag.
REQ-015 The block SHALL have port check_enable, input, width 1: enables sequence checking.
REQ-016 The block SHALL have port word_count, output, width 32: number of accepted input beats.
REQ-017 The block SHALL have port err_count, output, width 16: number of detected sequence errors.
REQ-018 The block SHALL have port mismatch, output, width 1: one-cycle pulse for each detected error.
REQ-019 The block SHALL have port sticky_err, output, width 1: set by the first error, held until reset.

Function
REQ-020 An input beat SHALL be accepted in any cycle where s00_axis_tvalid and s00_axis_tready are both 1.
REQ-021 An output beat SHALL be consumed in any cycle where m00_axis_tvalid and m00_axis_tready are both 1.
REQ-022 The FIFO SHALL store {tdata, tstrb, tlast} per entry and SHALL preserve beat order.
REQ-023 s00_axis_tready SHALL be 1 exactly when the FIFO occupancy is below FIFO_DEPTH; it is decoded from registered occupancy and never depends on m00_axis_tready combinationally.
REQ-024 m00_axis_tvalid SHALL be 1 exactly when the FIFO occupancy is nonzero, and m00_axis_tdata, tstrb and tlast SHALL show the head entry.
REQ-025 A beat accepted at edge N SHALL first appear on m00 after edge N (one-cycle latency), when the FIFO was empty.
REQ-026 A simultaneous accept and consume SHALL leave occupancy unchanged.
REQ-027 When the FIFO is full, no input beat SHALL be accepted, even if a consume happens in the same cycle.
REQ-028 m00 outputs SHALL stay stable while m00_axis_tvalid is 1 and m00_axis_tready is 0.
REQ-029 The read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 word_count SHALL increment on every accepted beat and SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 The checker SHALL have states ST_SEED and ST_TRACK and SHALL hold a register expected of width DATA_SIZE.
REQ-032 In ST_SEED, an accepted beat with check_enable=1 SHALL load expected <= tdata*3 (truncated to DATA_SIZE), SHALL NOT be compared, and SHALL move the checker to ST_TRACK.
REQ-033 In ST_TRACK, each accepted beat SHALL be compared with expected, and expected SHALL then be set to tdata*3 (truncated to DATA_SIZE), so it resyncs to the actual data.
REQ-034 On a compare mismatch, mismatch SHALL be 1 in the following cycle only, err_count SHALL increment saturating at 0xFFFF, and sticky_err SHALL be set to 1.
REQ-035 check_enable=0 in any cycle SHALL force ST_SEED at the next edge, and no compare SHALL occur in that cycle.
REQ-036 tlast and tstrb SHALL be passed through unchanged and SHALL have no effect on the checker.
REQ-037 Idle cycles (no accept) SHALL leave the checker state, expected and all counters unchanged.

Reset
REQ-038 While areset=1 at an edge, the block SHALL set occupancy and both pointers to 0, s00_axis_tready to 1 from the next cycle, m00_axis_tvalid to 0, m00_axis_tdata/tstrb/tlast to 0, the checker to ST_SEED, expected to 1, word_count and err_count to 0, and mismatch and sticky_err to 0.
REQ-039 A reset during operation SHALL discard all buffered beats, and no m00 beat SHALL be presented in the cycle after reset.

Verification
REQ-040 The bench SHALL drive beats 3, 9, 27, 81 with check_enable=1 and m00_axis_tready=1, and SHALL see the same four beats out in order with one-cycle latency, word_count=4, err_count=0 and sticky_err=0.
REQ-041 The bench SHALL drive beats 3, 9, 28, 84, 252, and SHALL see exactly one mismatch pulse, for 28, with err_count=1 and sticky_err=1.
REQ-042 The bench SHALL hold m00_axis_tready=0 and drive 6 beats, and SHALL see s00_axis_tready go to 0 after 4 accepts; after it then raises tready, all 4 beats SHALL drain in order.
REQ-043 The bench SHALL push and pop in the same cycle at occupancy 2, and SHALL see occupancy stay at 2 and output data ordering kept.
REQ-044 The bench SHALL drive beats 3, 9, drop check_enable for one beat of 5, then drive 15, 45, and SHALL see no error: 15 is the seed and 45 is checked.
REQ-045 The bench SHALL assert areset with 3 beats buffered, and SHALL see m00_axis_tvalid=0, word_count=0 and err_count=0 after reset, then a fresh 3, 9 sequence pass with no error.

Source files
------------

// File: rtl/axis_pow3_checker.sv
// AXI-Stream pass-through FIFO with a power-of-3 sequence checker on the input side.
// Each accepted beat (while checking) must equal three times the previous accepted beat.
module axis_pow3_checker #(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
  input  logic                   s00_axis_tvalid,
  output logic                   s00_axis_tready,
  input  logic                   s00_axis_tlast,
  output logic [DATA_SIZE-1:0]   m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
  output logic                   m00_axis_tvalid,
  input  logic                   m00_axis_tready,
  output logic                   m00_axis_tlast,
  input  logic                   check_enable,
  output logic [31:0]            word_count,
  output logic [15:0]            err_count,
  output logic                   mismatch,
  output logic                   sticky_err
);

  localparam int SW = DATA_SIZE / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_SEED,
    ST_TRACK
  } chk_state_e;

  logic [DATA_SIZE-1:0] data_mem_q [FIFO_DEPTH];
  logic [SW-1:0]        strb_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q, count_d;
  logic                 push, pop;

  chk_state_e           state_q;
  logic [DATA_SIZE-1:0] expected_q;
  logic [DATA_SIZE-1:0] tdata_x3;
  logic [31:0]          word_count_q;
  logic [15:0]          err_count_q;
  logic                 mismatch_q;
  logic                 sticky_q;

  // Ready is decoded from registered occupancy only, so a full FIFO never accepts.
  assign s00_axis_tready = (count_q != FULL_CNT);
  assign m00_axis_tvalid = (count_q != '0);
  assign push            = s00_axis_tvalid & s00_axis_tready;
  assign pop             = m00_axis_tvalid & m00_axis_tready;

  assign m00_axis_tdata  = m00_axis_tvalid ? data_mem_q[rd_ptr_q] : '0;
  assign m00_axis_tstrb  = m00_axis_tvalid ? strb_mem_q[rd_ptr_q] : '0;
  assign m00_axis_tlast  = m00_axis_tvalid & last_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= s00_axis_tdata;
      strb_mem_q[wr_ptr_q] <= s00_axis_tstrb;
      last_mem_q[wr_ptr_q] <= s00_axis_tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign tdata_x3 = s00_axis_tdata + (s00_axis_tdata << 1);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_SEED;
      expected_q   <= DATA_SIZE'(1);
      word_count_q <= '0;
      err_count_q  <= '0;
      mismatch_q   <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      if (push) word_count_q <= word_count_q + 32'd1;
      if (!check_enable) begin
        state_q <= ST_SEED;
      end else if (push) begin
        // Expected always resyncs to the actual data, so one bad beat gives one error.
        expected_q <= tdata_x3;
        state_q    <= ST_TRACK;
        if (state_q == ST_TRACK && s00_axis_tdata != expected_q) begin
          mismatch_q <= 1'b1;
          sticky_q   <= 1'b1;
          if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
        end
      end
    end
  end

  assign word_count = word_count_q;
  assign err_count  = err_count_q;
  assign mismatch   = mismatch_q;
  assign sticky_err = sticky_q;

endmodule

// File: tb/tb_axis_pow3_checker.sv
// Bench for axis_pow3_checker: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axis_pow3_checker;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [SW-1:0] s_tstrb = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b0;
  logic          check_enable = 1'b0;

  logic          s00_axis_tready;
  logic [DW-1:0] m00_axis_tdata;
  logic [SW-1:0] m00_axis_tstrb;
  logic          m00_axis_tvalid;
  logic          m00_axis_tlast;
  logic [31:0]   word_count;
  logic [15:0]   err_count;
  logic          mismatch;
  logic          sticky_err;

  axis_pow3_checker #(.DATA_SIZE(DW), .FIFO_DEPTH(DEPTH)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m00_axis_tlast),
    .check_enable    (check_enable),
    .word_count      (word_count),
    .err_count       (err_count),
    .mismatch        (mismatch),
    .sticky_err      (sticky_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  // Reference model: buffer contents as a queue, checker as "previous checked beat".
  beat_t         mq[$];
  bit            have_prev = 1'b0;
  logic [DW-1:0] prev = '0;
  logic [31:0]   m_wc = '0;
  int            m_ec = 0;
  bit            m_mm = 1'b0;
  bit            m_sticky = 1'b0;
  bit            model_ok = 1'b0;

  int            n_vec = 0;
  int            n_err = 0;
  int            pulses = 0;
  logic [DW-1:0] drained[$];
  beat_t         head;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge aclk) begin : model
    bit acc, con;
    if (areset) begin
      mq.delete();
      have_prev = 1'b0;
      m_wc      = '0;
      m_ec      = 0;
      m_mm      = 1'b0;
      m_sticky  = 1'b0;
    end else begin
      acc  = s_tvalid && (mq.size() < DEPTH);
      con  = (mq.size() > 0) && m_tready;
      m_mm = 1'b0;
      if (acc) begin
        m_wc = m_wc + 32'd1;
        if (check_enable) begin
          if (have_prev && s_tdata != DW'(prev * 32'd3)) begin
            m_mm     = 1'b1;
            m_sticky = 1'b1;
            if (m_ec < 65535) m_ec++;
          end
          prev      = s_tdata;
          have_prev = 1'b1;
        end
      end
      if (!check_enable) have_prev = 1'b0;
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back('{d: s_tdata, s: s_tstrb, l: s_tlast});
    end
  end

  always @(posedge aclk) begin
    if (!areset && m00_axis_tvalid && m_tready) drained.push_back(m00_axis_tdata);
  end

  always @(negedge aclk) begin
    if (model_ok) begin
      head = (mq.size() > 0) ? mq[0] : '0;
      chk("tvalid",   64'(m00_axis_tvalid), 64'(mq.size() != 0));
      chk("s_tready", 64'(s00_axis_tready), 64'(mq.size() < DEPTH));
      chk("tdata",    64'(m00_axis_tdata),  64'(head.d));
      chk("tstrb",    64'(m00_axis_tstrb),  64'(head.s));
      chk("tlast",    64'(m00_axis_tlast),  64'(head.l));
      chk("word_cnt", 64'(word_count),      64'(m_wc));
      chk("err_cnt",  64'(err_count),       64'(m_ec));
      chk("mismatch", 64'(mismatch),        64'(m_mm));
      chk("sticky",   64'(sticky_err),      64'(m_sticky));
      if (mismatch) pulses++;
    end
  end

  // All driver tasks start and end just after a falling edge.
  task automatic send(input logic [DW-1:0] d, input bit ce);
    int g;
    g        = 0;
    s_tdata  = d;
    s_tstrb  = SW'($urandom);
    s_tlast  = 1'($urandom);
    s_tvalid = 1'b1;
    check_enable = ce;
    while (!s00_axis_tready && g < 40) begin
      @(negedge aclk);
      g++;
    end
    if (g >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no accept for %0d expected accept", d);
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    areset   = 1'b1;
    @(negedge aclk);
    areset   = 1'b0;
    model_ok = 1'b1;
  endtask

  logic [DW-1:0] exp_a[4];
  int            acc_n;
  logic [DW-1:0] gen;
  logic [DW-1:0] nd;

  initial begin
    @(negedge aclk);
    check_enable = 1'b1;
    m_tready     = 1'b1;
    do_reset();

    chk("rst_tvalid",  64'(m00_axis_tvalid), 64'd0);
    chk("rst_tready",  64'(s00_axis_tready), 64'd1);
    chk("rst_tdata",   64'(m00_axis_tdata),  64'd0);
    chk("rst_wc",      64'(word_count),      64'd0);
    chk("rst_ec",      64'(err_count),       64'd0);
    chk("rst_sticky",  64'(sticky_err),      64'd0);

    // Clean power-of-3 run
    drained.delete();
    send(3, 1); send(9, 1); send(27, 1); send(81, 1);
    idle(3);
    exp_a = '{3, 9, 27, 81};
    chk("a_count", 64'(drained.size()), 64'd4);
    for (int i = 0; i < 4 && i < drained.size(); i++) chk("a_order", 64'(drained[i]), 64'(exp_a[i]));
    chk("a_wc", 64'(word_count), 64'd4);
    chk("a_ec", 64'(err_count),  64'd0);
    chk("a_sticky", 64'(sticky_err), 64'd0);

    // One bad beat, then resync
    do_reset();
    pulses = 0;
    send(3, 1); send(9, 1); send(28, 1); send(84, 1); send(252, 1);
    idle(3);
    chk("b_pulses", 64'(pulses),     64'd1);
    chk("b_ec",     64'(err_count),  64'd1);
    chk("b_sticky", 64'(sticky_err), 64'd1);

    // Backpressure until full, then drain
    do_reset();
    m_tready = 1'b0;
    acc_n    = 0;
    for (int i = 0; i < 8; i++) begin
      s_tdata  = DW'(100 + acc_n);
      s_tvalid = (acc_n < 6);
      check_enable = 1'b1;
      if (s00_axis_tready && s_tvalid) acc_n++;
      @(negedge aclk);
    end
    s_tvalid = 1'b0;
    chk("c_accepts", 64'(acc_n), 64'd4);
    chk("c_full_tready", 64'(s00_axis_tready), 64'd0);
    drained.delete();
    m_tready = 1'b1;
    idle(6);
    chk("c_drain_n", 64'(drained.size()), 64'd4);
    for (int i = 0; i < 4 && i < drained.size(); i++) chk("c_drain_order", 64'(drained[i]), 64'(100 + i));

    // Push and pop in the same cycle at occupancy 2
    do_reset();
    m_tready = 1'b0;
    send(200, 0); send(201, 0);
    drained.delete();
    m_tready = 1'b1;
    send(202, 0);
    m_tready = 1'b0;
    chk("d_one_popped", 64'(drained.size()), 64'd1);
    idle(2);
    m_tready = 1'b1;
    idle(4);
    exp_a = '{200, 201, 202, 0};
    chk("d_total", 64'(drained.size()), 64'd3);
    for (int i = 0; i < 3 && i < drained.size(); i++) chk("d_order", 64'(drained[i]), 64'(exp_a[i]));

    // check_enable drop reseeds the checker
    do_reset();
    pulses = 0;
    send(3, 1); send(9, 1); send(5, 0); send(15, 1); send(45, 1);
    idle(3);
    chk("e_pulses", 64'(pulses),    64'd0);
    chk("e_ec",     64'(err_count), 64'd0);
    chk("e_wc",     64'(word_count), 64'd5);

    // Reset with beats buffered
    do_reset();
    m_tready = 1'b0;
    send(1, 1); send(2, 1); send(3, 1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("f_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("f_wc",     64'(word_count),      64'd0);
    chk("f_ec",     64'(err_count),       64'd0);
    m_tready = 1'b1;
    pulses = 0;
    send(3, 1); send(9, 1);
    idle(3);
    chk("f_pulses", 64'(pulses),    64'd0);
    chk("f_ec2",    64'(err_count), 64'd0);
    chk("f_wc2",    64'(word_count), 64'd2);

    // Randomized traffic against the model
    do_reset();
    gen = 32'd1;
    for (int i = 0; i < 3000; i++) begin
      areset = ($urandom_range(0, 499) == 0);
      m_tready = ($urandom_range(0, 2) != 0);
      check_enable = ($urandom_range(0, 15) != 0);
      if (!s_tvalid || s00_axis_tready) begin
        nd = ($urandom_range(0, 4) == 0) ? DW'($urandom) : DW'(gen * 32'd3);
        s_tdata  = nd;
        s_tstrb  = SW'($urandom);
        s_tlast  = 1'($urandom);
        s_tvalid = ($urandom_range(0, 3) != 0);
      end
      if (s_tvalid && s00_axis_tready && !areset) gen = s_tdata;
      @(negedge aclk);
    end
    areset   = 1'b0;
    s_tvalid = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
